// File: rtl/set_injector.sv
// Drive-side SET command executor: parses a value and scans aliases one per clock,
// writing the first matching output entry and pulsing done or error.
module set_injector #(
  parameter int                   ARGS_NB   = 5,
  parameter int                   SET_SIZE  = 5,
  parameter int                   SET_WIDTH = 32,
  parameter logic [SET_WIDTH-1:0] RESET_VAL = '0,
  parameter int                   STR_LEN   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [SET_SIZE-1:0][STR_LEN*8-1:0]   i_set_alias,
  input  logic                                 i_sel_set,
  input  logic                                 i_args_valid,
  input  logic [ARGS_NB-1:0][STR_LEN*8-1:0]    i_args,
  output logic [SET_SIZE-1:0][SET_WIDTH-1:0]   o_set,
  output logic                                 o_set_done,
  output logic                                 o_set_error,
  output logic                                 o_busy
);

  localparam int SW    = STR_LEN * 8;
  localparam int IDX_W = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SET_SIZE - 1);
  localparam logic [SW-1:0]    CMD_SET  = {{(SW-24){1'b0}}, 24'h534554};

  typedef enum logic [0:0] {IDLE = 1'b0, SEARCH = 1'b1} state_e;

  // Strings are right-justified, NUL-padded; returns {valid, value truncated to SET_WIDTH}.
  function automatic logic [SET_WIDTH:0] parse_value(input logic [SW-1:0] s);
    logic [SET_WIDTH-1:0] val;
    logic [1:0]           mode;
    logic                 bad;
    logic                 is_dig;
    logic [3:0]           dig;
    logic [7:0]           c;
    logic [7:0]           first;
    int                   n;
    int                   ndig;
    val = '0; mode = 2'd0; bad = 1'b0; first = 8'h00; n = 0; ndig = 0;
    for (int i = STR_LEN - 1; i >= 0; i--) begin
      c      = s[i*8 +: 8];
      is_dig = 1'b0;
      dig    = 4'd0;
      if (n != 0 || c != 8'h00) begin
        if (n == 1 && first == 8'h30 && (c == 8'h78 || c == 8'h58)) begin
          mode = 2'd1;
          ndig = 0;
        end else if (n == 1 && first == 8'h30 && c == 8'h62) begin
          mode = 2'd2;
          ndig = 0;
        end else begin
          case (mode)
            2'd1: begin
              if (c >= 8'h30 && c <= 8'h39) begin
                dig = 4'(c - 8'h30); is_dig = 1'b1;
              end else if (c >= 8'h61 && c <= 8'h66) begin
                dig = 4'(c - 8'h57); is_dig = 1'b1;
              end else if (c >= 8'h41 && c <= 8'h46) begin
                dig = 4'(c - 8'h37); is_dig = 1'b1;
              end else begin
                is_dig = 1'b0;
              end
            end
            2'd2: begin
              if (c == 8'h30 || c == 8'h31) begin
                dig = 4'(c - 8'h30); is_dig = 1'b1;
              end else begin
                is_dig = 1'b0;
              end
            end
            default: begin
              if (c >= 8'h30 && c <= 8'h39) begin
                dig = 4'(c - 8'h30); is_dig = 1'b1;
              end else begin
                is_dig = 1'b0;
              end
            end
          endcase
          if (is_dig) begin
            case (mode)
              2'd1:    val = (val << 4) | SET_WIDTH'(dig);
              2'd2:    val = (val << 1) | SET_WIDTH'(dig[0]);
              default: val = val * SET_WIDTH'(10) + SET_WIDTH'(dig);
            endcase
            ndig = ndig + 1;
          end else begin
            bad = 1'b1;
          end
        end
        if (n == 0) begin
          first = c;
        end else begin
          first = first;
        end
        n = n + 1;
      end else begin
        n = n;
      end
    end
    return {(!bad && ndig != 0), val};
  endfunction

  state_e                               state_q;
  logic [IDX_W-1:0]                     idx_q;
  logic [SW-1:0]                        alias_q;
  logic [SET_WIDTH-1:0]                 value_q;
  logic                                 vvalid_q;
  logic [SET_SIZE-1:0][SET_WIDTH-1:0]   set_q;
  logic                                 done_q;
  logic                                 error_q;
  logic                                 busy_q;
  logic [SET_WIDTH:0]                   parse_d;
  logic                                 accept_s;

  assign parse_d  = parse_value(i_args[2]);
  assign accept_s = i_sel_set && i_args_valid && (i_args[0] == CMD_SET);

  generate
    if (ARGS_NB > 3) begin : g_extra_args
      logic unused_args_s;
      assign unused_args_s = ^i_args[ARGS_NB-1:3];
    end
  endgenerate

  // Command FSM: accept in IDLE, one alias compare per clock in SEARCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      alias_q  <= '0;
      value_q  <= '0;
      vvalid_q <= 1'b0;
      set_q    <= {SET_SIZE{RESET_VAL}};
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            alias_q  <= i_args[1];
            value_q  <= parse_d[SET_WIDTH-1:0];
            vvalid_q <= parse_d[SET_WIDTH];
            idx_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= SEARCH;
          end else begin
            busy_q   <= 1'b0;
          end
        end
        SEARCH: begin
          if (alias_q == i_set_alias[idx_q]) begin
            if (vvalid_q) begin
              set_q[idx_q] <= value_q;
              done_q       <= 1'b1;
            end else begin
              error_q      <= 1'b1;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (idx_q == LAST_IDX) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_set       = set_q;
  assign o_set_done  = done_q;
  assign o_set_error = error_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_set_injector.sv
// Directed bench for set_injector: a 32-bit and an 8-bit instance share the command bus.
module tb_set_injector;

  logic                clk;
  logic                rst_n;
  logic [4:0][127:0]   aliases;
  logic [4:0][127:0]   args;
  logic                args_valid;
  logic                sel32;
  logic                sel8;
  logic [4:0][31:0]    o_set32;
  logic [4:0][7:0]     o_set8;
  logic                done32, err32, busy32;
  logic                done8, err8, busy8;

  int n_checks = 0;
  int n_fail   = 0;

  set_injector #(.SET_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .i_set_alias(aliases), .i_sel_set(sel32),
    .i_args_valid(args_valid), .i_args(args), .o_set(o_set32),
    .o_set_done(done32), .o_set_error(err32), .o_busy(busy32)
  );

  set_injector #(.SET_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_set_alias(aliases), .i_sel_set(sel8),
    .i_args_valid(args_valid), .i_args(args), .o_set(o_set8),
    .o_set_done(done8), .o_set_error(err8), .o_busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single edge (E0); returns just after E0.
  task automatic send(input bit s32, input bit s8, input logic [127:0] a0,
                      input logic [127:0] a1, input logic [127:0] a2);
    args[0] = a0; args[1] = a1; args[2] = a2; args[3] = '0; args[4] = '0;
    sel32 = s32; sel8 = s8; args_valid = 1'b1;
    step();
    args_valid = 1'b0; sel32 = 1'b0; sel8 = 1'b0;
  endtask

  // Watch 8 edges: first pulse offset, pulse counts, busy cycles.
  task automatic observe(input bit w8, output int lat, output int nd, output int ne,
                         output int nb);
    int both;
    lat = 0; nd = 0; ne = 0; nb = 0; both = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (w8 ? done8 : done32) nd++;
      if (w8 ? err8 : err32) ne++;
      if (w8 ? busy8 : busy32) nb++;
      if ((w8 ? done8 : done32) && (w8 ? err8 : err32)) both++;
      if (lat == 0 && ((w8 ? done8 : done32) || (w8 ? err8 : err32))) lat = k;
    end
    check("done_and_error_together", both, 0);
  endtask

  int lat, nd, ne, nb;

  initial begin
    rst_n = 1'b0; args_valid = 1'b0; sel32 = 1'b0; sel8 = 1'b0; args = '0;
    aliases[0] = "I0"; aliases[1] = "I1"; aliases[2] = "I2";
    aliases[3] = "I3"; aliases[4] = "I4";
    repeat (3) step();
    for (int k = 0; k < 5; k++) begin
      check("reset_oset32", o_set32[k], 32'h0);
      check("reset_oset8", {24'h0, o_set8[k]}, 32'h0);
    end
    check("reset_flags32", {29'h0, done32, err32, busy32}, 32'h0);
    check("reset_flags8", {29'h0, done8, err8, busy8}, 32'h0);
    rst_n = 1'b1;
    step();

    // Hex value to index 2
    send(1'b1, 1'b0, "SET", "I2", "0x5A");
    check("busy_after_accept", {31'h0, busy32}, 32'h1);
    observe(1'b0, lat, nd, ne, nb);
    check("i2_latency", lat, 3);
    check("i2_done_cnt", nd, 1);
    check("i2_err_cnt", ne, 0);
    check("i2_busy_cycles", nb, 2);
    check("i2_value", o_set32[2], 32'h0000005A);
    check("i2_others", o_set32[0] | o_set32[1] | o_set32[3] | o_set32[4], 32'h0);

    // Mixed-case hex and decimal truncation on the wide instance
    send(1'b1, 1'b0, "SET", "I0", "0XdeadBEEF");
    observe(1'b0, lat, nd, ne, nb);
    check("i0_hex_latency", lat, 1);
    check("i0_hex_value", o_set32[0], 32'hDEADBEEF);
    send(1'b1, 1'b0, "SET", "I4", "4294967301");
    observe(1'b0, lat, nd, ne, nb);
    check("i4_dec_trunc", o_set32[4], 32'h5);
    check("i4_dec_done", nd, 1);

    // 8-bit instance: decimal, truncated hex, binary
    send(1'b0, 1'b1, "SET", "I4", "255");
    observe(1'b1, lat, nd, ne, nb);
    check("w8_i4_latency", lat, 5);
    check("w8_i4_value", {24'h0, o_set8[4]}, 32'hFF);
    send(1'b0, 1'b1, "SET", "I4", "0x1FF");
    observe(1'b1, lat, nd, ne, nb);
    check("w8_trunc_done", nd, 1);
    check("w8_trunc_value", {24'h0, o_set8[4]}, 32'hFF);
    send(1'b0, 1'b1, "SET", "I0", "0b101");
    observe(1'b1, lat, nd, ne, nb);
    check("w8_bin_value", {24'h0, o_set8[0]}, 32'h05);
    check("w8_untouched_by_wide", o_set32[0], 32'hDEADBEEF);

    // Error paths
    send(1'b1, 1'b0, "SET", "FOO", "1");
    observe(1'b0, lat, nd, ne, nb);
    check("foo_latency", lat, 5);
    check("foo_err_cnt", ne, 1);
    check("foo_done_cnt", nd, 0);
    check("foo_unchanged", o_set32[2], 32'h5A);
    send(1'b1, 1'b0, "SET", "I1", "0xZZ");
    observe(1'b0, lat, nd, ne, nb);
    check("zz_latency", lat, 2);
    check("zz_err_cnt", ne, 1);
    check("zz_unchanged", o_set32[1], 32'h0);
    send(1'b1, 1'b0, "SET", "I3", "-5");
    observe(1'b0, lat, nd, ne, nb);
    check("neg_latency", lat, 4);
    check("neg_err_cnt", ne, 1);
    send(1'b1, 1'b0, "SET", "I3", "");
    observe(1'b0, lat, nd, ne, nb);
    check("empty_err_cnt", ne, 1);
    send(1'b1, 1'b0, "SET", "I3", "0x");
    observe(1'b0, lat, nd, ne, nb);
    check("bare_prefix_err_cnt", ne, 1);
    check("errors_left_i3", o_set32[3], 32'h0);

    // Ignored requests: wrong command word, not selected
    send(1'b1, 1'b0, "GET", "I2", "1");
    check("get_no_busy", {31'h0, busy32}, 32'h0);
    observe(1'b0, lat, nd, ne, nb);
    check("get_no_pulse", nd + ne, 0);
    send(1'b0, 1'b0, "SET", "I2", "1");
    observe(1'b0, lat, nd, ne, nb);
    check("unsel_no_pulse", nd + ne, 0);
    check("unsel_value", o_set32[2], 32'h5A);

    // Request while busy is dropped
    send(1'b1, 1'b0, "SET", "I3", "7");
    send(1'b1, 1'b0, "SET", "I0", "9");
    observe(1'b0, lat, nd, ne, nb);
    check("busy_req_latency", lat, 3);
    check("busy_req_done_cnt", nd, 1);
    check("busy_req_i3", o_set32[3], 32'h7);
    check("busy_req_i0", o_set32[0], 32'hDEADBEEF);

    // Request on the done edge is dropped
    send(1'b1, 1'b0, "SET", "I0", "1");
    send(1'b1, 1'b0, "SET", "I1", "2");
    check("b2b_done_pulse", {31'h0, done32}, 32'h1);
    check("b2b_i0", o_set32[0], 32'h1);
    observe(1'b0, lat, nd, ne, nb);
    check("b2b_no_second", nd + ne, 0);
    check("b2b_i1", o_set32[1], 32'h0);

    // Duplicate alias: lowest index wins
    aliases[3] = "I2";
    send(1'b1, 1'b0, "SET", "I2", "0x11");
    observe(1'b0, lat, nd, ne, nb);
    check("dup_latency", lat, 3);
    check("dup_low", o_set32[2], 32'h11);
    check("dup_high", o_set32[3], 32'h7);
    aliases[3] = "I3";

    // Reset during SEARCH aborts the command
    send(1'b1, 1'b0, "SET", "I3", "0x33");
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_i3", o_set32[3], 32'h0);
    check("midrst_i2", o_set32[2], 32'h0);
    check("midrst_busy", {31'h0, busy32}, 32'h0);
    step();
    check("midrst_pulses", {30'h0, done32, err32}, 32'h0);
    rst_n = 1'b1;
    step();
    send(1'b1, 1'b0, "SET", "I3", "7");
    observe(1'b0, lat, nd, ne, nb);
    check("post_rst_latency", lat, 4);
    check("post_rst_done", nd, 1);
    check("post_rst_i3", o_set32[3], 32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/set_injector.md
Name: set_injector

Overview:
- Testbench-side driver block: executes SET commands from the scenario sequencer and drives named stimulus signals into the DUT.
- Drive-side counterpart of wait_event, which observes named DUT outputs. Consumes the same alias array and args/valid handshake, and returns done/error status to the sequencer.
- Alias lookup is a sequential scan, one alias per clock.

Parameters:
- ARGS_NB, 5, number of string arguments per command line.
- SET_SIZE, 5, number of drivable aliases/outputs.
- SET_WIDTH, 32, bit width of each driven output.
- RESET_VAL, 0, value loaded into every o_set entry on reset.

Ports:
- clk  input  1  testbench clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_set_alias  input  string[SET_SIZE]  alias name for each output index.
- i_sel_set  input  1  sequencer selects this block for the current command.
- i_args_valid  input  1  i_args holds a valid command this cycle.
- i_args  input  string[ARGS_NB]  args[0]="SET", args[1]=alias, args[2]=value text.
- o_set  output  [SET_WIDTH-1:0][SET_SIZE]  driven stimulus values.
- o_set_done  output  1  one-cycle pulse: command applied.
- o_set_error  output  1  one-cycle pulse: command rejected.
- o_busy  output  1  command in progress.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - every o_set entry = RESET_VAL;
  - o_set_done = 0, o_set_error = 0, o_busy = 0;
  - FSM = IDLE, index = 0.
- States: IDLE, SEARCH.
- Accept (edge E0): in IDLE with i_sel_set=1, i_args_valid=1 and args[0]=="SET":
  - latch args[1] and args[2];
  - parse the value;
  - index <= 0, o_busy <= 1, go to SEARCH.
- Sampling outside the accept condition:
  - args[0] != "SET" with i_sel_set=1 and i_args_valid=1: no action.
  - i_sel_set=0: i_args is ignored.
- Value parse, done at accept:
  - "0x"/"0X" prefix: hex. "0b" prefix: binary. Otherwise: unsigned decimal.
  - Result is truncated to SET_WIDTH LSBs.
  - Empty string, illegal character or leading '-' marks the command invalid. The scan still runs, but ends in error (see below).
- SEARCH, edge E0+1+k compares the latched alias with i_set_alias[k]:
  - Match and value valid: o_set[k] <= value, o_set_done <= 1, o_busy <= 0, go to IDLE.
  - Match and value invalid: o_set_error <= 1, o_set unchanged, o_busy <= 0, go to IDLE.
  - No match and k < SET_SIZE-1: index <= k+1.
  - No match and k = SET_SIZE-1: o_set_error <= 1, o_busy <= 0, go to IDLE.
- Latency: an alias at index k updates at edge E0+1+k. Worst case is SET_SIZE cycles after accept.
- Done/error pulses: exactly one cycle wide and never asserted together.
- Duplicate aliases: the lowest index wins; higher duplicates are never written.
- Request while o_busy=1: ignored, not queued, no pulse. The sequencer must wait for done/error.
- Back-to-back: a new request sampled on the same edge that produces done/error is ignored. The block accepts again from the following edge.
- o_set holding: entries hold their value indefinitely. Only a matching SET or reset changes them. Other entries are never disturbed.
- Reset mid-SEARCH: the command is aborted, no done/error pulse, and all o_set entries return to RESET_VAL.
- Alias compare: exact, case-sensitive string equality.

Test Plan:
- Reset (aliases I0..I4, SET_WIDTH=32) -> hold rst_n=0 -> every o_set = 0, o_set_done = 0, o_set_error = 0, o_busy = 0.
- "SET I2 0x5A" accepted at E0 -> o_set[2]=0x0000005A at E0+3; o_set_done high for exactly one cycle; o_busy high E0..E0+3; other entries stay 0.
- With SET_WIDTH=8: "SET I4 255" -> o_set[4]=0xFF at E0+5. Then "SET I4 0x1FF" -> o_set[4]=0xFF (truncated), done pulse.
- "SET FOO 1" -> o_set_error one-cycle pulse at E0+5, no done pulse, all o_set unchanged. "SET I1 0xZZ" -> error pulse at E0+2, o_set[1] unchanged.
- Issue "SET I3 7" -> drive "SET I0 9" at E0+1 while busy -> only o_set[3]=7 at E0+4, one done pulse, o_set[0] unchanged.
- Issue "SET I3 7" -> pull rst_n low between E0+2 and E0+3 -> o_set[3]=0, no done/error pulse, o_busy=0. A fresh "SET I3 7" after reset completes normally.
